// File: rtl/detect_event_logger.sv
// rtl/detect_event_logger.sv - timestamped FIFO logger for sequence-detector hits
//
// Purpose: each cycle the upstream detector is high while enabled, the current
// free-running timestamp is appended to a small FIFO. Detections that arrive
// while the FIFO is full and not being drained are dropped and flagged. All
// detections are counted with a saturating counter.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   detector_in  1 = detection this cycle
//   enable       1 = timestamp runs and detections are sampled
//   clear        synchronous clear of all logger state (beats everything else)
//   rd_ready     consumer accepts the head entry
//   rd_valid     FIFO non-empty
//   rd_data      timestamp held in the head entry
//   fifo_level   entries held, 0..DEPTH
//   event_count  saturating count of all detections (stored or dropped)
//   overflow     sticky: a detection was dropped
module detect_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   detector_in,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [TS_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_WIDTH-1:0]   event_count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  logic event_fire;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Outputs come straight from registers (level, head pointer, storage), so
  // there is no combinational path from detector_in or rd_ready to them.
  assign rd_valid = (fifo_level != '0);
  assign rd_data  = mem[rd_ptr];

  assign event_fire = enable & detector_in;
  assign full       = (fifo_level == FULL_LEVEL);
  assign pop        = rd_valid & rd_ready;
  // A full FIFO still accepts a new entry when the head leaves on the same edge.
  assign push       = event_fire & (~full | pop);
  assign drop       = event_fire & full & ~pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (enable) begin
        ts <= ts + TS_WIDTH'(1);
      end

      // Pointers are PTR_W bits wide and DEPTH is a power of two, so they
      // wrap modulo DEPTH without extra logic.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end

      if (event_fire && (event_count != '1)) begin
        event_count <= event_count + CNT_WIDTH'(1);
      end

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; pointers and level define which entries are live.
  // The logged value is ts before this edge's increment.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem[wr_ptr] <= ts;
    end
  end

endmodule

// File: tb/tb_detect_event_logger.sv
// tb/tb_detect_event_logger.sv - scoreboard bench for detect_event_logger
module tb_detect_event_logger;

  logic        clock;
  logic        reset;
  logic        detector_in;
  logic        enable;
  logic        clear;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  fifo_level;
  logic [15:0] event_count;
  logic        overflow;

  logic        s_det;
  logic        s_en;
  logic        s_clear;
  logic        s_rd_ready;
  logic        s_rd_valid;
  logic [3:0]  s_rd_data;
  logic [1:0]  s_fifo_level;
  logic [1:0]  s_event_count;
  logic        s_overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  detect_event_logger #(.TS_WIDTH(16), .DEPTH(8), .CNT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset), .detector_in(detector_in), .enable(enable),
    .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_level(fifo_level), .event_count(event_count), .overflow(overflow)
  );

  detect_event_logger #(.TS_WIDTH(4), .DEPTH(2), .CNT_WIDTH(2)) u_small (
    .clock(clock), .reset(reset), .detector_in(s_det), .enable(s_en),
    .clear(s_clear), .rd_ready(s_rd_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
    .fifo_level(s_fifo_level), .event_count(s_event_count), .overflow(s_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted head entry is compared against the scoreboard.
  always @(negedge clock) begin
    if (reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        check("rd_data_order", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; detector_in = 1'b0; enable = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    s_det = 1'b0; s_en = 1'b0; s_clear = 1'b0; s_rd_ready = 1'b0;
    #1;
    check("reset_rd_valid", 32'(rd_valid), 0);
    check("reset_level", 32'(fifo_level), 0);
    check("reset_count", 32'(event_count), 0);
    check("reset_overflow", 32'(overflow), 0);
    #2;
    reset = 1'b1;
    enable = 1'b1;

    // Single event at ts=5
    repeat (5) tick();
    detector_in = 1'b1; exp_q.push_back(16'd5);
    tick();
    detector_in = 1'b0;
    check("single_rd_valid", 32'(rd_valid), 1);
    check("single_rd_data", 32'(rd_data), 5);
    check("single_count", 32'(event_count), 1);
    check("single_level", 32'(fifo_level), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("single_drained", 32'(rd_valid), 0);

    // Burst at ts=10,11,12 (ts is 7 here)
    repeat (3) tick();
    detector_in = 1'b1;
    exp_q.push_back(16'd10); exp_q.push_back(16'd11); exp_q.push_back(16'd12);
    repeat (3) tick();
    detector_in = 1'b0;
    check("burst_level", 32'(fifo_level), 3);
    check("burst_count", 32'(event_count), 4);
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    check("burst_drained", 32'(rd_valid), 0);

    // Clear, then 10 events from ts=0 into an 8-deep FIFO
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_count", 32'(event_count), 0);
    check("clear_level", 32'(fifo_level), 0);
    detector_in = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
    repeat (8) tick();
    check("full_level", 32'(fifo_level), 8);
    check("full_no_overflow_yet", 32'(overflow), 0);
    repeat (2) tick();
    detector_in = 1'b0;
    check("ovf_level", 32'(fifo_level), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(event_count), 10);

    // Full FIFO: event at ts=20 with simultaneous pop
    repeat (10) tick();
    detector_in = 1'b1; rd_ready = 1'b1; exp_q.push_back(16'd20);
    tick();
    detector_in = 1'b0;
    check("pushpop_level", 32'(fifo_level), 8);
    check("pushpop_overflow", 32'(overflow), 1);
    check("pushpop_count", 32'(event_count), 11);
    repeat (8) tick();
    rd_ready = 1'b0;
    check("pushpop_drained", 32'(rd_valid), 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    // Reset mid-run with 3 entries and overflow set (not scoreboarded)
    detector_in = 1'b1;
    repeat (3) tick();
    detector_in = 1'b0;
    check("pre_reset_level", 32'(fifo_level), 3);
    check("pre_reset_overflow", 32'(overflow), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rd_valid", 32'(rd_valid), 0);
    check("async_level", 32'(fifo_level), 0);
    check("async_count", 32'(event_count), 0);
    check("async_overflow", 32'(overflow), 0);
    #1;
    reset = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("empty_pop_level", 32'(fifo_level), 0);
    check("empty_pop_valid", 32'(rd_valid), 0);

    // Small instance: TS_WIDTH=4 wrap, DEPTH=2, 2-bit saturating count
    s_en = 1'b1;
    repeat (15) tick();
    s_det = 1'b1;
    repeat (2) tick();
    check("wrap_level", 32'(s_fifo_level), 2);
    check("wrap_head", 32'(s_rd_data), 15);
    check("wrap_count", 32'(s_event_count), 2);
    check("wrap_no_overflow", 32'(s_overflow), 0);
    tick();
    check("small_drop_count", 32'(s_event_count), 3);
    check("small_overflow", 32'(s_overflow), 1);
    tick();
    s_det = 1'b0;
    check("small_saturate", 32'(s_event_count), 3);
    check("small_drop_level", 32'(s_fifo_level), 2);
    s_rd_ready = 1'b1;
    tick();
    check("wrap_second", 32'(s_rd_data), 0);
    check("wrap_second_level", 32'(s_fifo_level), 1);
    tick();
    s_rd_ready = 1'b0;
    check("small_drained", 32'(s_rd_valid), 0);
    s_det = 1'b1; s_clear = 1'b1;
    tick();
    s_det = 1'b0; s_clear = 1'b0;
    check("clear_evt_count", 32'(s_event_count), 0);
    check("clear_evt_level", 32'(s_fifo_level), 0);
    check("clear_evt_overflow", 32'(s_overflow), 0);
    check("clear_evt_valid", 32'(s_rd_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/detect_event_logger.md
DETECT_EVENT_LOGGER -- requirements
Module: detect_event_logger

Interface
REQ-001 Parameter TS_WIDTH, default 16: width of the timestamp counter and the read data.
REQ-002 Parameter DEPTH, default 8: number of FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter CNT_WIDTH, default 16: width of the event counter.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-006 detector_in  input  1  level output of the upstream Moore sequence detector; 1 = detection this cycle.
REQ-007 enable  input  1  1 = timestamp runs and detections are sampled; 0 = both frozen.
REQ-008 clear  input  1  synchronous clear of all logger state.
REQ-009 rd_ready  input  1  consumer accepts the head entry this cycle.
REQ-010 rd_valid  output  1  FIFO holds at least one entry.
REQ-011 rd_data  output  TS_WIDTH  timestamp of the head entry.
REQ-012 fifo_level  output  clog2(DEPTH)+1  number of entries held, 0..DEPTH.
REQ-013 event_count  output  CNT_WIDTH  total detections sampled, stored and dropped.
REQ-014 overflow  output  1  sticky flag: one or more detections dropped.

Function
REQ-015 Timestamp ts SHALL be a TS_WIDTH register, +1 per clock while enable=1, held while enable=0, wrapping from all-ones to 0.
REQ-016 Event: a rising edge with enable=1 and detector_in=1; each such cycle is one event, so N consecutive high cycles are N events.
REQ-017 Each event SHALL log the value of ts before that edge's increment.
REQ-018 Push on an event when fifo_level<DEPTH, or when fifo_level=DEPTH and a pop occurs at the same edge.
REQ-019 Pop SHALL occur when rd_valid=1 and rd_ready=1; rd_ready while rd_valid=0 has no effect.
REQ-020 Push and pop together: level unchanged, head advances, new entry appended at the tail.
REQ-021 Drop: an event while full with no pop SHALL NOT be stored, SHALL set overflow=1, and SHALL leave FIFO contents unchanged.
REQ-022 Latency: an entry pushed at edge N SHALL give rd_valid=1 and, if the FIFO was empty, rd_data equal to that entry after edge N.
REQ-023 rd_valid and rd_data SHALL be registered or derived only from registers; no combinational path from detector_in or rd_ready to any output.
REQ-024 Read order SHALL be FIFO; read and write pointers wrap modulo DEPTH.
REQ-025 event_count SHALL increment on every event (stored or dropped) and saturate at all-ones.
REQ-026 overflow SHALL stay 1 until reset or clear.
REQ-027 clear=1 at an edge: ts, pointers, fifo_level, event_count and overflow go to 0; clear beats any same-edge push, pop or event, and that event is not counted.
REQ-028 rd_data SHALL be don't-care while rd_valid=0.

Reset
REQ-029 reset=0 SHALL asynchronously force ts=0, pointers=0, fifo_level=0, rd_valid=0, event_count=0, overflow=0, including mid-operation.
REQ-030 On release, the first active edge SHALL act as in REQ-015..027; FIFO storage needs no reset.

Verification
REQ-031 Reset mid-run: 3 entries held and overflow=1, reset pulsed low between edges -> rd_valid=0, fifo_level=0, event_count=0, overflow=0 immediately, before any edge.
REQ-032 Single event: enable=1 from release, detector_in high for one cycle at ts=5 -> next cycle rd_valid=1, rd_data=5, event_count=1; one rd_ready pulse -> rd_valid=0.
REQ-033 Burst: detector_in high at ts=10,11,12 with rd_ready=0 -> fifo_level=3; then rd_ready=1 -> reads 10,11,12 in order, then rd_valid=0.
REQ-034 Overflow: DEPTH=8, 10 consecutive events from ts=0 with rd_ready=0 -> fifo_level=8, overflow=1, event_count=10, reads 0..7.
REQ-035 Full push+pop: FIFO full holding 0..7, event at ts=20 with rd_ready=1 -> fifo_level=8, overflow unchanged, reads 1..7 then 20.
REQ-036 Wrap and clear: TS_WIDTH=4, event at ts=15 and next edge -> logs 15 then 0; clear asserted with detector_in=1 -> all counts 0 and no entry stored.
